// File: rtl/uart_receiver.sv
// 8N1 UART receiver, OVERSAMPLE ticks per bit; byte out ~3+OVERSAMPLE/2+9*OVERSAMPLE cycles after start edge, no backpressure.
// Define UART_RX_MAJORITY_VOTE_EN to take each sample as the 2-of-3 majority of the last three synchronized values.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baudrate_clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       rx_ferr,
    output logic       rx_busy
);
    localparam int CW = (OVERSAMPLE > 16) ? $clog2(OVERSAMPLE) : 4;
    localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_TICK = CW'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("OVERSAMPLE must be a power of two, at least 8");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [7:0]      data_nxt;
    logic            status_nxt, ferr_nxt;
    logic            sync1, rx_sync;
    logic            sample;

    always_ff @(posedge baudrate_clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            sync1   <= uart_rx;
            rx_sync <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // rx_hist[0] is the current rx_sync, [2:1] the two preceding cycles.
    logic [1:0] rx_prev;
    logic [2:0] rx_hist;

    always_ff @(posedge baudrate_clk) begin
        if (reset) begin
            rx_prev <= 2'b11;
        end else begin
            rx_prev <= {rx_prev[0], rx_sync};
        end
    end

    assign rx_hist = {rx_prev, rx_sync};
    assign sample  = (rx_hist[0] & rx_hist[1]) | (rx_hist[0] & rx_hist[2]) | (rx_hist[1] & rx_hist[2]);
`else
    assign sample = rx_sync;
`endif

    always_ff @(posedge baudrate_clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_status <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            rx_data   <= data_nxt;
            rx_status <= status_nxt;
            rx_ferr   <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        data_nxt    = rx_data;
        status_nxt  = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_sync) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == HALF_TICK) begin
                    cnt_nxt = '0;
                    if (!sample) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_TICK) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {sample, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == FULL_TICK) begin
                    cnt_nxt = '0;
                    if (sample) begin
                        data_nxt   = shift;
                        status_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BREAK: begin
                // Wait out a held-low line so it yields a single framing error.
                if (rx_sync) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 ticks per bit; line driven on the falling clock edge.
module tb_uart_receiver;
    logic       clk;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rx_ferr;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int start_cyc = 0;
    int status_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int busy_cyc = 0;
    int status_cyc_q[$];
    logic [7:0] data_q[$];

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .baudrate_clk(clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_status   (rx_status),
        .rx_ferr     (rx_ferr),
        .rx_busy     (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_status) begin
                status_cnt++;
                status_cyc_q.push_back(cyc);
                data_q.push_back(rx_data);
            end
            if (rx_ferr) ferr_cnt++;
            if (rx_status && rx_ferr) both_cnt++;
            if (rx_busy) busy_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit,
                              input int abort_bit, input int stop_len);
        start_cyc = cyc + 1;
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            if (i == abort_bit) begin
                repeat (8) @(negedge clk);
                reset   = 1'b1;
                uart_rx = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (i == glitch_bit) begin
                repeat (8) @(negedge clk);
                uart_rx = ~d[i];
                @(negedge clk);
                uart_rx = d[i];
                repeat (7) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
        uart_rx = stop;
        repeat (stop_len) @(negedge clk);
    endtask

    initial begin
        int s0, f0, b0, q0, lat;
        logic [7:0] maj_exp;

        uart_rx = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_status", rx_status, 1'b0);
        chk("rst_ferr", rx_ferr, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single good frame and its latency.
        s0 = status_cnt; f0 = ferr_cnt; q0 = status_cyc_q.size();
        send_frame(8'hA5, 1'b1, -1, -1, 16);
        lat = status_cyc_q[q0] - start_cyc;
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_status_cnt", status_cnt - s0, 1);
        chk("a5_ferr_cnt", ferr_cnt - f0, 0);
        chk("a5_latency_155pm1", (lat >= 154 && lat <= 156), 1'b1);
        repeat (4) @(negedge clk);
        chk("a5_idle_busy", rx_busy, 1'b0);

        // Back-to-back frames, no idle gap.
        s0 = status_cnt; q0 = status_cyc_q.size();
        send_frame(8'h00, 1'b1, -1, -1, 16);
        send_frame(8'hFF, 1'b1, -1, -1, 16);
        chk("b2b_status_cnt", status_cnt - s0, 2);
        chk("b2b_data0", data_q[q0], 8'h00);
        chk("b2b_data1", data_q[q0+1], 8'hFF);
        chk("b2b_spacing", status_cyc_q[q0+1] - status_cyc_q[q0], 160);

        // Short low pulse: false start rejected.
        s0 = status_cnt; f0 = ferr_cnt; b0 = busy_cyc;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_status", status_cnt - s0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_busy_le10", (busy_cyc - b0) <= 10, 1'b1);
        chk("glitch_busy_seen", (busy_cyc - b0) > 0, 1'b1);
        chk("glitch_data_kept", rx_data, 8'hFF);

        // Stop bit low, line held low for 40 cycles.
        s0 = status_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, -1, -1, 40);
        chk("ferr_cnt", ferr_cnt - f0, 1);
        chk("ferr_status", status_cnt - s0, 0);
        chk("ferr_data_kept", rx_data, 8'hFF);
        chk("ferr_break_busy", rx_busy, 1'b1);
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("ferr_idle_busy", rx_busy, 1'b0);
        chk("ferr_single", ferr_cnt - f0, 1);

        // Reset in the middle of data bit 4, then a clean frame.
        repeat (10) @(negedge clk);
        s0 = status_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b1, -1, 4, 16);
        chk("rstmid_busy", rx_busy, 1'b0);
        chk("rstmid_data", rx_data, 8'h00);
        repeat (20) @(negedge clk);
        chk("rstmid_no_status", status_cnt - s0, 0);
        chk("rstmid_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h81, 1'b1, -1, -1, 16);
        chk("rstmid_81_data", rx_data, 8'h81);
        chk("rstmid_81_status", status_cnt - s0, 1);

        // One-cycle inverted glitch on the data bit 2 sample point.
`ifdef UART_RX_MAJORITY_VOTE_EN
        maj_exp = 8'h55;
`else
        maj_exp = 8'h51;
`endif
        repeat (10) @(negedge clk);
        send_frame(8'h55, 1'b1, 2, -1, 16);
        chk("vote_data", rx_data, maj_exp);

        repeat (10) @(negedge clk);
        chk("never_status_and_ferr", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
